// File: rtl/router_pkt_gen.sv
// rtl/router_pkt_gen.sv - packet transmitter driving the 1x3 router input port
//
// Purpose: accepts a packet request (destination, payload length, seed) and
// emits header, payload and trailing parity bytes, holding each byte while
// the router reports busy.
//
// Ports:
//   clock      in   1   rising-edge clock
//   reset      in   1   asynchronous active-high reset
//   start      in   1   request strobe, sampled while ready=1
//   dest       in   2   destination port 0..2 (3 is rejected)
//   length     in   6   payload byte count 1..63 (0 is rejected)
//   seed       in   8   first payload byte; byte i = seed + i
//   busy       in   1   router busy; current byte is not consumed
//   pkt_valid  out  1   high during header and payload bytes
//   pkt_data   out  8   byte to the router data input
//   ready      out  1   high while idle
//   done       out  1   one-cycle pulse after the parity byte is consumed
//   err        out  1   one-cycle pulse when a request is rejected
//   pkt_count  out 16   completed packet count (wraps)

module router_pkt_gen (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  dest,
  input  logic [5:0]  length,
  input  logic [7:0]  seed,
  input  logic        busy,
  output logic        pkt_valid,
  output logic [7:0]  pkt_data,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [15:0] pkt_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HEADER  = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_PARITY  = 2'd3;

  logic [1:0] r_state;
  logic [5:0] r_len;
  logic [7:0] r_seed;
  logic [5:0] r_idx;
  logic [7:0] r_parity;

  logic       w_legal;
  logic       w_consume;
  logic       w_last;
  logic [5:0] w_idx_inc;
  logic [7:0] w_parity_next;

  assign w_legal       = (dest != 2'd3) && (length != 6'd0);
  assign w_consume     = !busy;
  assign w_last        = (r_idx == (r_len - 6'd1));
  assign w_idx_inc     = r_idx + 6'd1;
  // Parity folds in the byte currently presented, so it only advances on
  // the edge where that byte is actually consumed.
  assign w_parity_next = r_parity ^ pkt_data;

  assign ready = (r_state == S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_len     <= 6'd0;
      r_seed    <= 8'd0;
      r_idx     <= 6'd0;
      r_parity  <= 8'd0;
      pkt_valid <= 1'b0;
      pkt_data  <= 8'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      pkt_count <= 16'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_legal) begin
              r_len     <= length;
              r_seed    <= seed;
              r_parity  <= 8'd0;
              pkt_valid <= 1'b1;
              pkt_data  <= {length, dest};
              r_state   <= S_HEADER;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_HEADER: begin
          if (w_consume) begin
            r_parity <= w_parity_next;
            r_idx    <= 6'd0;
            pkt_data <= r_seed;
            r_state  <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (w_consume) begin
            r_parity <= w_parity_next;
            if (w_last) begin
              // Parity byte is presented with pkt_valid low.
              pkt_valid <= 1'b0;
              pkt_data  <= w_parity_next;
              r_state   <= S_PARITY;
            end else begin
              r_idx    <= w_idx_inc;
              pkt_data <= r_seed + {2'b00, w_idx_inc};
            end
          end
        end
        S_PARITY: begin
          if (w_consume) begin
            pkt_data  <= 8'd0;
            done      <= 1'b1;
            pkt_count <= pkt_count + 16'd1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
